// File: rtl/bmp280_spi_reader.sv
// bmp280_spi_reader
// SPI mode-0 master that configures a BMP280 once and then periodically
// reads the raw pressure burst (0xF7..0xF9), presenting it as a 24-bit word.

module bmp280_spi_reader #(
    parameter int unsigned CLK_DIV        = 25,
    parameter int unsigned STARTUP_CYCLES = 100000,
    parameter int unsigned SAMPLE_PERIOD  = 5000000,
    parameter logic [7:0]  CTRL_MEAS      = 8'h27
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        spi_csb,
    output logic        spi_sck,
    output logic        spi_sdi,
    input  logic        spi_sdo,
    output logic [23:0] adc_p,
    output logic        adc_valid,
    output logic        busy,
    output logic        cfg_done
);

    // Outgoing frames, left-aligned so bit 31 is the first bit on the wire
    localparam logic [31:0] CFG_WORD  = {8'h74, CTRL_MEAS, 16'h0000};
    localparam logic [31:0] READ_WORD = 32'hF700_0000;

    typedef enum logic [1:0] {
        ST_STARTUP,
        ST_CFG,
        ST_WAIT,
        ST_READ
    } state_t;

    state_t      state;
    logic [31:0] cnt;
    logic [6:0]  half;
    logic [31:0] tx;
    logic [23:0] rx;
    logic        load_pending;
    logic [6:0]  last_half;

    // Index of the trailing SCK-low half period: 16 half periods per byte
    assign last_half = (state == ST_READ) ? 7'd64 : 7'd32;

    // Sequencer, SPI bit engine and result register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_STARTUP;
            cnt          <= '0;
            half         <= '0;
            tx           <= '0;
            rx           <= '0;
            load_pending <= 1'b0;
            spi_csb      <= 1'b1;
            spi_sck      <= 1'b0;
            spi_sdi      <= 1'b0;
            adc_p        <= '0;
            adc_valid    <= 1'b0;
            busy         <= 1'b0;
            cfg_done     <= 1'b0;
        end else begin
            adc_valid <= 1'b0;
            if (load_pending) begin
                adc_p        <= rx;
                adc_valid    <= 1'b1;
                load_pending <= 1'b0;
            end

            case (state)
                ST_STARTUP: begin
                    if (cnt == STARTUP_CYCLES - 1) begin
                        state   <= ST_CFG;
                        cnt     <= '0;
                        half    <= '0;
                        tx      <= CFG_WORD;
                        spi_csb <= 1'b0;
                        busy    <= 1'b1;
                        spi_sck <= 1'b0;
                        spi_sdi <= CFG_WORD[31];
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                ST_WAIT: begin
                    if (cnt == SAMPLE_PERIOD - 1) begin
                        state   <= ST_READ;
                        cnt     <= '0;
                        half    <= '0;
                        tx      <= READ_WORD;
                        spi_csb <= 1'b0;
                        busy    <= 1'b1;
                        spi_sck <= 1'b0;
                        spi_sdi <= READ_WORD[31];
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                ST_CFG, ST_READ: begin
                    if (cnt == CLK_DIV - 1) begin
                        cnt <= '0;
                        if (half == last_half) begin
                            // Trailing low phase done: release chip select
                            spi_csb <= 1'b1;
                            busy    <= 1'b0;
                            spi_sck <= 1'b0;
                            spi_sdi <= 1'b0;
                            if (state == ST_READ) begin
                                load_pending <= 1'b1;
                            end else begin
                                cfg_done <= 1'b1;
                            end
                            state <= ST_WAIT;
                        end else begin
                            half <= half + 7'd1;
                            if (!half[0]) begin
                                // Rising SCK: sample the sensor; bytes 2..4 of a read carry data
                                spi_sck <= 1'b1;
                                if ((state == ST_READ) && (half >= 7'd16)) begin
                                    rx <= {rx[22:0], spi_sdo};
                                end
                            end else begin
                                // Falling SCK: launch the next outgoing bit
                                spi_sck <= 1'b0;
                                tx      <= {tx[30:0], 1'b0};
                                spi_sdi <= tx[30];
                            end
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                default: begin
                    state <= ST_STARTUP;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
